// File: rtl/srl_fifo.sv
// srl_fifo: valid/ready FIFO built on an enable-gated shift chain so synthesis maps storage onto SRL16E/SRLC32E primitives with a dynamic read address.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_data write side;
//   out_valid/out_ready/out_data read side; count = entries held.
// Build option: define SRL_FIFO_OUTREG_EN to add a registered output stage (capacity DEPTH+1).
module srl_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
`ifdef SRL_FIFO_OUTREG_EN
  // extra output entry raises capacity to DEPTH+1, which must fit in count
  parameter int AW = $clog2(DEPTH + 2)
`else
  parameter int AW = $clog2(DEPTH + 1)
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [AW-1:0]    count
);
  localparam int RW = $clog2(DEPTH);
  logic [WIDTH-1:0] sr [DEPTH];
  logic [AW-1:0]    cnt;
  logic [RW-1:0]    ra;
  logic             push;
  logic             deq;
  assign in_ready = cnt != AW'(DEPTH);
  assign push     = in_valid & in_ready;
  // head is the oldest entry, cnt-1 stages down the chain
  assign ra       = RW'(cnt - AW'(1));
  // no reset and push as the sole enable keep the chain SRL-mappable
  always_ff @(posedge clk) begin
    if (push) begin
      sr[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt + AW'(push) - AW'(deq);
  end
`ifdef SRL_FIFO_OUTREG_EN
  logic             ovalid;
  logic [WIDTH-1:0] oreg;
  // refill the output flop whenever it is empty or being consumed
  assign deq = (cnt != '0) & (!ovalid | out_ready);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovalid <= 1'b0;
      oreg   <= '0;
    end else begin
      ovalid <= deq | (ovalid & !out_ready);
      if (deq) oreg <= sr[ra];
    end
  end
  assign out_valid = ovalid;
  assign out_data  = oreg;
  assign count     = cnt + AW'(ovalid);
`else
  assign out_valid = cnt != '0;
  assign deq       = out_valid & out_ready;
  assign out_data  = sr[ra];
  assign count     = cnt;
`endif
endmodule
